multiplier_arbiter_56: RTL and testbench
========================================

// Module: multiplier_arbiter_56
// PURPOSE
// - Shares one pipelined 56x56 multiplier (multiplier_middle_bit) among N_REQ requesters.
// - Round-robin grant per cycle; tags each issue and tracks it down the fixed-latency pipe.
// - Buffers results in a response FIFO with credit control, so rsp back-pressure never drops a product.
// - Sits between the modular-arithmetic requesters and the single shared DSP multiplier.
// PARAMETERS
// - N_REQ      4   number of requesters (>=2)
// - ID_W       2   requester id width, clog2(N_REQ)
// - MUL_SIZE   56  operand width
// - RES_W      54  result width = multiplier output width (RADIX)
// - MUL_LAT    3   multiplier latency, a/b sampled -> res valid
// - FIFO_DEPTH 8   response FIFO entries (power of 2, >= MUL_LAT+1)
// PORTS
// - clk        in   1               clock, rising edge
// - rst        in   1               synchronous reset, active-high
// - req_valid  in   N_REQ           per-requester operand valid
// - req_ready  out  N_REQ           per-requester accept (one-hot or zero)
// - req_a      in   N_REQ*MUL_SIZE  operand a; slice i = requester i
// - req_b      in   N_REQ*MUL_SIZE  operand b; slice i = requester i
// - mul_rst_n  out  1               multiplier reset = ~rst
// - mul_a      out  MUL_SIZE        registered operand a to multiplier
// - mul_b      out  MUL_SIZE        registered operand b to multiplier
// - mul_res    in   RES_W           multiplier result
// - rsp_valid  out  1               FIFO head valid
// - rsp_ready  in   1               consumer accepts head
// - rsp_id     out  ID_W            requester id of head
// - rsp_res    out  RES_W           product slice of head
// - busy       out  1               any op in flight or FIFO not empty
// BEHAVIOUR
// - Reset: req_ready=0, mul_a=mul_b=0, rsp_valid=0, rsp_id=0, rsp_res=0, busy=0.
//   Tag pipe and FIFO are cleared; RR pointer = N_REQ-1, so requester 0 wins first.
// - Credit: issue_ok = (fifo_count + inflight) < FIFO_DEPTH.
//   Pop in the same cycle is not credited (conservative).
// - Grant (combinational): if issue_ok, the first valid requester after the RR pointer, wrapping.
//   req_ready = grant one-hot; accept = req_valid[i] & req_ready[i].
//   req_ready is never high without req_valid.
// - On accept in cycle C0:
//   - mul_a/mul_b <= slice i (valid in C1).
//   - Tag pipe stage 0 <= {1, i}.
//   - RR pointer <= i.
//   - With no accept, mul_a/mul_b hold their values and stage 0 <= invalid.
// - Tag pipe: MUL_LAT+1 stages, shifts every cycle, no stall.
//   The last stage is valid in C1+MUL_LAT (C4 by default), aligned with mul_res.
// - Result capture: if the last stage is valid, FIFO push {id, mul_res} at the end of C4.
//   With the FIFO empty, rsp_valid rises in C5, so accept-to-rsp latency = MUL_LAT+2.
//   Credit guarantees the FIFO is never full on a push; overflow is impossible by construction.
// - FIFO: pop when rsp_valid & rsp_ready.
//   Simultaneous push and pop on a non-empty FIFO: count unchanged.
//   When empty, a push is not visible until the next cycle (no bypass).
//   Pointers wrap modulo FIFO_DEPTH.
// - Throughput: 1 op/cycle sustained while rsp_ready=1.
//   inflight = number of valid tag stages (0..MUL_LAT+1).
// - Ordering: responses leave in issue order; rsp_id identifies the owner.
// - Multiplier internals are partly unreset, so garbage on mul_res after reset is ignored.
//   Only valid tags push.
// - Reset mid-operation drops all in-flight ops and FIFO contents; no response is emitted for them.
// - busy = |tag_valid | (fifo_count != 0).
// CONFIGURATION
// - MUL_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins.
//   RR pointer logic is removed; everything else is unchanged.
// - Not defined (default): round-robin as above.
// TESTING
// - Single op: req0 with a=56'h40000000000000 (2^54), b=5 accepted in C0.
//   -> rsp_valid in C5, rsp_id=0, rsp_res=5; busy low after the pop.
// - RR fairness: all 4 requesters held valid with rsp_ready=1.
//   -> grants 0,1,2,3,0,... one per cycle; responses in the same id order.
// - Fixed priority (macro defined): same stimulus -> requester 0 granted every cycle; 1-3 starve.
// - Back-pressure: rsp_ready=0, req0 always valid.
//   -> exactly FIFO_DEPTH=8 accepts, then req_ready=0.
//   -> Raise rsp_ready: 8 responses drain in order, then issue resumes; no loss, no duplicates.
// - Simultaneous push/pop at fifo_count=7 with rsp_ready=1 -> count stays 7; data order preserved.
// - Reset pulse with 3 ops in flight and 2 in the FIFO.
//   -> rsp_valid=0 and busy=0 the cycle after; no stale response ever appears.

Source files
------------

// File: rtl/multiplier_arbiter_56.sv
// Shares one pipelined 56x56 middle-bit multiplier among N_REQ requesters with credit-controlled response FIFO.
// Define MUL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module multiplier_arbiter_56 #(
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2,
    parameter int MUL_SIZE   = 56,
    parameter int RES_W      = 54,
    parameter int MUL_LAT    = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*MUL_SIZE-1:0] req_a,
    input  logic [N_REQ*MUL_SIZE-1:0] req_b,
    output logic                      mul_rst_n,
    output logic [MUL_SIZE-1:0]       mul_a,
    output logic [MUL_SIZE-1:0]       mul_b,
    input  logic [RES_W-1:0]          mul_res,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [RES_W-1:0]          rsp_res,
    output logic                      busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NSTG  = MUL_LAT + 1;
    localparam int INF_W = $clog2(NSTG + 1);
    localparam int OCC_W = CNT_W + 1;

    logic [MUL_SIZE-1:0]   a_sl [N_REQ];
    logic [MUL_SIZE-1:0]   b_sl [N_REQ];

    logic [NSTG-1:0]       tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]       tag_id_q [NSTG];
    logic [MUL_SIZE-1:0]   mul_a_q, mul_a_d;
    logic [MUL_SIZE-1:0]   mul_b_q, mul_b_d;
    logic [ID_W+RES_W-1:0] mem_q [FIFO_DEPTH];
    logic [ID_W+RES_W-1:0] head;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [INF_W-1:0]      inflight;
    logic [OCC_W-1:0]      occ;
    logic                  issue_ok;
    logic                  found;
    logic                  accept;
    logic [ID_W-1:0]       gnt_id;
    logic                  push;
    logic                  pop;

`ifndef MUL_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]       rr_q, rr_d;
    logic [ID_W-1:0]       idx;
`endif

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign a_sl[g] = req_a[g*MUL_SIZE +: MUL_SIZE];
        assign b_sl[g] = req_b[g*MUL_SIZE +: MUL_SIZE];
    end

    // Credit counts every op from issue until its response is popped; a same-cycle pop is not credited.
    always_comb begin
        inflight = '0;
        for (int s = 0; s < NSTG; s++) begin
            inflight = inflight + INF_W'(tag_vld_q[s]);
        end
    end

    assign occ      = OCC_W'(count_q) + OCC_W'(inflight);
    assign issue_ok = occ < OCC_W'(FIFO_DEPTH);

    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
`ifdef MUL_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found  = 1'b1;
                gnt_id = ID_W'(i);
            end
        end
`else
        idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(rr_q) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
`endif
        if (!issue_ok) begin
            found = 1'b0;
        end
    end

    assign accept    = found;
    assign req_ready = accept ? (N_REQ'(1) << gnt_id) : '0;

    assign push = tag_vld_q[NSTG-1];
    assign pop  = rsp_valid & rsp_ready;

    always_comb begin
        tag_vld_d = {tag_vld_q[NSTG-2:0], accept};
        mul_a_d   = accept ? a_sl[gnt_id] : mul_a_q;
        mul_b_d   = accept ? b_sl[gnt_id] : mul_b_q;
        wr_ptr_d  = wr_ptr_q + PTR_W'(push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
`ifndef MUL_ARB_FIXED_PRIO_EN
        rr_d      = accept ? gnt_id : rr_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_q <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
`ifndef MUL_ARB_FIXED_PRIO_EN
            rr_q      <= ID_W'(N_REQ - 1);
`endif
        end else begin
            tag_vld_q <= tag_vld_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
`ifndef MUL_ARB_FIXED_PRIO_EN
            rr_q      <= rr_d;
`endif
        end
    end

    // Ids ride alongside the multiplier pipe; only valid tags capture mul_res, so its unreset garbage is never stored.
    always_ff @(posedge clk) begin
        tag_id_q[0] <= gnt_id;
        for (int s = 1; s < NSTG; s++) begin
            tag_id_q[s] <= tag_id_q[s-1];
        end
        if (push) begin
            mem_q[wr_ptr_q] <= {tag_id_q[NSTG-1], mul_res};
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign rsp_valid = (count_q != '0);
    assign rsp_id    = rsp_valid ? head[ID_W+RES_W-1:RES_W] : '0;
    assign rsp_res   = rsp_valid ? head[RES_W-1:0] : '0;
    assign busy      = (|tag_vld_q) | rsp_valid;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_rst_n = ~rst;

endmodule

// File: tb/tb_multiplier_arbiter_56.sv
// Bench for multiplier_arbiter_56: behavioural multiplier stand-in plus an occupancy/queue reference model.
module tb_multiplier_arbiter_56;

    localparam int N_REQ      = 4;
    localparam int ID_W       = 2;
    localparam int MUL_SIZE   = 56;
    localparam int RES_W      = 54;
    localparam int MUL_LAT    = 3;
    localparam int FIFO_DEPTH = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ-1:0]          req_ready;
    logic [N_REQ*MUL_SIZE-1:0] req_a;
    logic [N_REQ*MUL_SIZE-1:0] req_b;
    logic                      mul_rst_n;
    logic [MUL_SIZE-1:0]       mul_a;
    logic [MUL_SIZE-1:0]       mul_b;
    logic [RES_W-1:0]          mul_res;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [RES_W-1:0]          rsp_res;
    logic                      busy;

    int vectors = 0;
    int fails   = 0;

    multiplier_arbiter_56 #(
        .N_REQ(N_REQ), .ID_W(ID_W), .MUL_SIZE(MUL_SIZE), .RES_W(RES_W),
        .MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_rst_n(mul_rst_n), .mul_a(mul_a),
        .mul_b(mul_b), .mul_res(mul_res), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_res(rsp_res), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [RES_W-1:0] mulfn(input logic [MUL_SIZE-1:0] a, input logic [MUL_SIZE-1:0] b);
        logic [2*MUL_SIZE-1:0] p;
        p = {{MUL_SIZE{1'b0}}, a} * {{MUL_SIZE{1'b0}}, b};
        return p[RES_W+54-1:54];
    endfunction

    // Multiplier stand-in: product of sampled operands appears MUL_LAT edges later.
    logic [RES_W-1:0] m1, m2, m3;
    always @(posedge clk) begin
        m1 <= mulfn(mul_a, mul_b);
        m2 <= m1;
        m3 <= m2;
    end
    assign mul_res = m3;

    typedef struct {
        int              c;
        logic [ID_W-1:0] id;
        logic [RES_W-1:0] res;
    } op_t;

    op_t              mq[$];
    int               ptr;
    int               t;
    logic [N_REQ-1:0] exp_ready;
    logic             exp_rv;
    logic [ID_W-1:0]  exp_id;
    logic [RES_W-1:0] exp_res;
    logic             exp_busy;

    // Reference: an op occupies a credit from the cycle after issue until popped,
    // and is visible at the FIFO head MUL_LAT+2 cycles after issue.
    always @(negedge clk) begin : model
        int win;
        logic [ID_W-1:0] ix;
        op_t o;
        if (rst) begin
            mq.delete();
            ptr = N_REQ - 1;
            t   = 0;
        end else begin
            win = -1;
            if (mq.size() < FIFO_DEPTH) begin
`ifdef MUL_ARB_FIXED_PRIO_EN
                for (int i = 0; i < N_REQ; i++) if (win < 0 && req_valid[i]) win = i;
`else
                for (int k = 1; k <= N_REQ; k++) begin
                    ix = ID_W'((ptr + k) % N_REQ);
                    if (win < 0 && req_valid[ix]) win = int'(ix);
                end
`endif
            end
            exp_ready = (win >= 0) ? (N_REQ'(1) << win) : '0;
            exp_rv    = (mq.size() > 0) && (mq[0].c + MUL_LAT + 2 <= t);
            exp_id    = exp_rv ? mq[0].id : '0;
            exp_res   = exp_rv ? mq[0].res : '0;
            exp_busy  = (mq.size() != 0);
            if (exp_rv && rsp_ready) void'(mq.pop_front());
            if (win >= 0) begin
                o.c  = t;
                o.id = ID_W'(win);
                for (int i = 0; i < N_REQ; i++)
                    if (i == win) o.res = mulfn(req_a[i*MUL_SIZE +: MUL_SIZE], req_b[i*MUL_SIZE +: MUL_SIZE]);
                mq.push_back(o);
                ptr = win;
            end
            t++;
        end
    end

    function automatic void rand_ops();
        for (int i = 0; i < N_REQ; i++) begin
            if ($urandom_range(7) == 0) req_a[i*MUL_SIZE +: MUL_SIZE] = '1;
            else req_a[i*MUL_SIZE +: MUL_SIZE] = MUL_SIZE'({$urandom, $urandom});
            req_b[i*MUL_SIZE +: MUL_SIZE] = MUL_SIZE'({$urandom, $urandom});
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk); #1;
        vectors++;
        if (mul_rst_n !== 1'b0) begin $display("FAIL reset_mul_rst_n got=%b exp=0", mul_rst_n); fails++; end
        vectors++;
        if ({req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_res, busy} !== '0) begin
            $display("FAIL reset_outputs rdy=%b a=%h b=%h rv=%b id=%0d res=%h busy=%b exp all 0",
                     req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_res, busy);
            fails++;
        end
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 4'hf;
        @(negedge clk); #1;
        vectors++;
        if (mul_rst_n !== 1'b1) begin $display("FAIL run_mul_rst_n got=%b exp=1", mul_rst_n); fails++; end
        vectors++;
        if (req_ready !== 4'b0001) begin $display("FAIL first_winner got=%b exp=0001", req_ready); fails++; end
        vectors++;
        if ({rsp_valid, busy} !== 2'b00) begin $display("FAIL post_reset_idle rv=%b busy=%b exp 0 0", rsp_valid, busy); fails++; end
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    task automatic test_single_op();
        int lat;
        lat = -1;
        do_reset();
        rsp_ready = 1'b1;
        req_a = '0; req_b = '0;
        req_a[MUL_SIZE-1:0] = 56'h40000000000000;
        req_b[MUL_SIZE-1:0] = 56'd5;
        req_valid = 4'b0001;
        @(negedge clk); #1;
        vectors++;
        if (req_ready !== 4'b0001) begin $display("FAIL single_accept got=%b exp=0001", req_ready); fails++; end
        @(posedge clk); #1;
        req_valid = '0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk); #1;
            if (rsp_valid === 1'b1) begin lat = n; break; end
            @(posedge clk); #1;
        end
        vectors++;
        if (lat != MUL_LAT + 2) begin $display("FAIL single_latency got=%0d exp=%0d", lat, MUL_LAT + 2); fails++; end
        vectors++;
        if (rsp_id !== 2'd0) begin $display("FAIL single_id got=%0d exp=0", rsp_id); fails++; end
        vectors++;
        if (rsp_res !== 54'd5) begin $display("FAIL single_res got=%h exp=5", rsp_res); fails++; end
        @(posedge clk); #1;
        @(negedge clk); #1;
        vectors++;
        if ({rsp_valid, busy} !== 2'b00) begin $display("FAIL single_idle rv=%b busy=%b exp 0 0", rsp_valid, busy); fails++; end
    endtask

    task automatic test_rr_fairness();
        int grants[$];
        int ids[$];
        int e;
        do_reset();
        rsp_ready = 1'b1;
        for (int n = 0; n < 26; n++) begin
            req_valid = (n < 16) ? 4'hf : 4'h0;
            rand_ops();
            @(negedge clk); #1;
            vectors++;
            if ({req_ready, rsp_valid, rsp_id, rsp_res, busy} !== {exp_ready, exp_rv, exp_id, exp_res, exp_busy}) begin
                $display("FAIL rr_cycle n=%0d rdy=%b/%b rv=%b/%b id=%0d/%0d res=%h/%h busy=%b/%b", n,
                         req_ready, exp_ready, rsp_valid, exp_rv, rsp_id, exp_id, rsp_res, exp_res, busy, exp_busy);
                fails++;
            end
            for (int i = 0; i < N_REQ; i++) if (req_ready[i] && req_valid[i]) grants.push_back(i);
            if (rsp_valid && rsp_ready) ids.push_back(int'(rsp_id));
            @(posedge clk); #1;
        end
        vectors++;
        if (grants.size() != 16 || ids.size() != 16) begin
            $display("FAIL rr_counts grants=%0d rsps=%0d exp 16 16", grants.size(), ids.size()); fails++;
        end
        for (int k = 0; k < 16; k++) begin
`ifdef MUL_ARB_FIXED_PRIO_EN
            e = 0;
`else
            e = k % N_REQ;
`endif
            if (k < grants.size()) begin
                vectors++;
                if (grants[k] != e) begin $display("FAIL rr_grant k=%0d got=%0d exp=%0d", k, grants[k], e); fails++; end
            end
            if (k < ids.size()) begin
                vectors++;
                if (ids[k] != e) begin $display("FAIL rr_rsp_id k=%0d got=%0d exp=%0d", k, ids[k], e); fails++; end
            end
        end
    endtask

    task automatic test_back_pressure();
        int acc, pops, acc2;
        acc = 0; pops = 0; acc2 = 0;
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        for (int n = 0; n < 50; n++) begin
            if (n == 20) rsp_ready = 1'b1;
            rand_ops();
            @(negedge clk); #1;
            vectors++;
            if ({req_ready, rsp_valid, rsp_id, rsp_res, busy} !== {exp_ready, exp_rv, exp_id, exp_res, exp_busy}) begin
                $display("FAIL bp_cycle n=%0d rdy=%b/%b rv=%b/%b id=%0d/%0d res=%h/%h busy=%b/%b", n,
                         req_ready, exp_ready, rsp_valid, exp_rv, rsp_id, exp_id, rsp_res, exp_res, busy, exp_busy);
                fails++;
            end
            if (req_ready[0] && req_valid[0]) begin
                if (n < 20) acc++; else acc2++;
            end
            if (rsp_valid && rsp_ready) pops++;
            if (n == 19) begin
                vectors++;
                if (req_ready !== 4'b0000) begin $display("FAIL bp_stalled got=%b exp=0000", req_ready); fails++; end
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (acc != FIFO_DEPTH) begin $display("FAIL bp_accepts got=%0d exp=%0d", acc, FIFO_DEPTH); fails++; end
        vectors++;
        if (pops < FIFO_DEPTH || acc2 == 0) begin $display("FAIL bp_drain pops=%0d resumed=%0d exp >=8 and >0", pops, acc2); fails++; end
        req_valid = '0;
    endtask

    task automatic test_push_pop_at_7();
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'hf;
        for (int n = 0; n < 45; n++) begin
            if (n == 11) rsp_ready = 1'b1;
            if (n == 30) req_valid = 4'h0;
            rand_ops();
            @(negedge clk); #1;
            vectors++;
            if ({req_ready, rsp_valid, rsp_id, rsp_res, busy} !== {exp_ready, exp_rv, exp_id, exp_res, exp_busy}) begin
                $display("FAIL pp7_cycle n=%0d rdy=%b/%b rv=%b/%b id=%0d/%0d res=%h/%h busy=%b/%b", n,
                         req_ready, exp_ready, rsp_valid, exp_rv, rsp_id, exp_id, rsp_res, exp_res, busy, exp_busy);
                fails++;
            end
            if (n == 11) begin
                vectors++;
                if (req_ready !== 4'b0000) begin $display("FAIL pp7_no_credit got=%b exp=0000", req_ready); fails++; end
            end
            if (n == 12) begin
                vectors++;
                if ({rsp_valid, rsp_id, busy} !== {1'b1, 2'd1, 1'b1}) begin
                    $display("FAIL pp7_head rv=%b id=%0d busy=%b exp 1 1 1", rsp_valid, rsp_id, busy); fails++;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midop();
        int acc;
        acc = 0;
        do_reset();
        rsp_ready = 1'b0;
        for (int n = 0; n < 10; n++) begin
            req_valid = (n < 2 || (n >= 6 && n < 9)) ? 4'hf : 4'h0;
            rand_ops();
            if (n == 9) rst = 1'b1;
            @(negedge clk); #1;
            if (!rst) begin
                vectors++;
                if ({req_ready, rsp_valid, rsp_id, rsp_res, busy} !== {exp_ready, exp_rv, exp_id, exp_res, exp_busy}) begin
                    $display("FAIL rstmid_cycle n=%0d rdy=%b/%b rv=%b/%b busy=%b/%b", n,
                             req_ready, exp_ready, rsp_valid, exp_rv, busy, exp_busy);
                    fails++;
                end
                for (int i = 0; i < N_REQ; i++) if (req_ready[i] && req_valid[i]) acc++;
            end
            @(posedge clk); #1;
        end
        rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        vectors++;
        if (acc != 5) begin $display("FAIL rstmid_setup accepts got=%0d exp=5", acc); fails++; end
        for (int n = 0; n < 12; n++) begin
            @(negedge clk); #1;
            vectors++;
            if ({rsp_valid, busy} !== 2'b00) begin
                $display("FAIL rstmid_flush n=%0d rv=%b busy=%b exp 0 0", n, rsp_valid, busy); fails++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 330; n++) begin
            req_valid = (n < 300) ? N_REQ'($urandom) : '0;
            rsp_ready = (n < 300) ? ($urandom_range(9) < 7) : 1'b1;
            rand_ops();
            @(negedge clk); #1;
            vectors++;
            if ({req_ready, rsp_valid, rsp_id, rsp_res, busy} !== {exp_ready, exp_rv, exp_id, exp_res, exp_busy}) begin
                $display("FAIL rand_cycle n=%0d rdy=%b/%b rv=%b/%b id=%0d/%0d res=%h/%h busy=%b/%b", n,
                         req_ready, exp_ready, rsp_valid, exp_rv, rsp_id, exp_id, rsp_res, exp_res, busy, exp_busy);
                fails++;
            end
            @(posedge clk); #1;
        end
        vectors++;
        if ({rsp_valid, busy} !== 2'b00) begin $display("FAIL rand_final_idle rv=%b busy=%b exp 0 0", rsp_valid, busy); fails++; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
        test_reset();
        test_single_op();
        test_rr_fairness();
        test_back_pressure();
        test_push_pop_at_7();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
